// File: rtl/radix2_bfly_pipe.sv
// radix2_bfly_pipe
//   Pipelined radix-2 decimation-in-time butterfly for a pipelined FFT:
//     X = A + W*B,  Y = A - W*B,  W = W_N^k from an internal twiddle ROM.
//   Three register stages (operands/twiddle, products, outputs). Sustains one
//   vector per cycle and supports backpressure on the output.
//
// Parameters
//   DATA_W  signed width of each real/imag input and output component
//   TW_W    signed twiddle width, Q2.(TW_W-2): +1.0 = 2^(TW_W-2) (TW_W >= 3)
//   N       FFT size, power of two >= 4; the ROM holds N/2 twiddles
//   SCALE   1: halve X and Y (rounded) before narrowing; 0: no scaling
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid, in_ready   input handshake
//   a_re, a_im           operand A
//   b_re, b_im           operand B
//   tw_idx               twiddle index k (0..N/2-1), sampled on accept
//   out_valid, out_ready output handshake
//   x_re, x_im           A + W*B
//   y_re, y_im           A - W*B
//   ovf                  qualified by out_valid: a component clipped
//
// Build option
//   BFLY_SAT_EN  defined: final narrowing saturates and ovf reports clipping.
//                undefined: final narrowing wraps (keeps low bits), ovf = 0.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A valid source holds its data stable until the transfer; ready may
// depend combinationally on the sink's downstream ready (in_ready does).
module radix2_bfly_pipe #(
    parameter int DATA_W = 8,
    parameter int TW_W   = 8,
    parameter int N      = 8,
    parameter int SCALE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic [$clog2(N)-2:0]     tw_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] x_re,
    output logic signed [DATA_W-1:0] x_im,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im,
    output logic                     ovf
);

    localparam int PW = DATA_W + TW_W;   // product width
    localparam int EW = PW + 2;          // stage-3 arithmetic width, never overflows
    localparam int FB = 28;              // fraction bits of the elaboration-time trig

    localparam logic signed [EW-1:0] ONE = 1;
    localparam logic signed [EW-1:0] RND = ONE <<< (TW_W - 3);

    // Twiddle generator evaluated at elaboration only. Integer Taylor series
    // on an angle folded into [0, pi/2]; cos(t) = -cos(pi - t) for t > pi/2.
    // Result is rounded to nearest in Q2.(TW_W-2). want_im selects -sin.
    function automatic longint tw_calc(input int k, input bit want_im);
        longint pi_fx, phi, p2, c, s, tc, ts, r;
        bit     flip;
        pi_fx = 64'sd843314857;          // round(pi * 2^28)
        if (4 * k > N) begin
            flip = 1'b1;
            phi  = (pi_fx * longint'(N - 2 * k)) / longint'(N);
        end else begin
            flip = 1'b0;
            phi  = (pi_fx * longint'(2 * k)) / longint'(N);
        end
        p2 = (phi * phi) >>> FB;
        c  = longint'(1) <<< FB;
        s  = phi;
        tc = c;
        ts = s;
        for (int i = 1; i <= 12; i++) begin
            tc = -((tc * p2) >>> FB) / longint'((2 * i - 1) * (2 * i));
            ts = -((ts * p2) >>> FB) / longint'((2 * i) * (2 * i + 1));
            c  = c + tc;
            s  = s + ts;
        end
        if (flip) c = -c;
        r = want_im ? -s : c;
        return (r * (longint'(1) <<< (TW_W - 2)) + (longint'(1) <<< (FB - 1))) >>> FB;
    endfunction

    logic signed [TW_W-1:0] rom_wr [N/2];
    logic signed [TW_W-1:0] rom_wi [N/2];

    for (genvar g = 0; g < N / 2; g++) begin : g_rom
        localparam logic signed [TW_W-1:0] WR = TW_W'(tw_calc(g, 1'b0));
        localparam logic signed [TW_W-1:0] WI = TW_W'(tw_calc(g, 1'b1));
        assign rom_wr[g] = WR;
        assign rom_wi[g] = WI;
    end

    // Returns {clip, narrowed value}. clip flags a value outside DATA_W range.
    function automatic logic [DATA_W:0] narrow(input logic signed [EW-1:0] v);
        logic              clip;
        logic [DATA_W-1:0] r;
        clip = (v[EW-1:DATA_W-1] != {(EW-DATA_W+1){v[EW-1]}});
`ifdef BFLY_SAT_EN
        if (clip) r = v[EW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else      r = v[DATA_W-1:0];
`else
        r = v[DATA_W-1:0];
`endif
        return {clip, r};
    endfunction

    // Stage valid bits and load enables. A stage loads when it is empty or
    // its contents move on this cycle; the chain runs combinationally from
    // out_ready so a full pipe still accepts while the output is taken.
    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = !rst && en1;
    assign out_valid = v3;

    // Stage 1: operands and twiddle
    logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [TW_W-1:0]   s1_wr, s1_wi;
    // Stage 2: A passes through, four partial products
    logic signed [DATA_W-1:0] s2_ar, s2_ai;
    logic signed [PW-1:0]     s2_rr, s2_ii, s2_ri, s2_ir;

    // Stage 3 combinational: complex product, rounding, add/sub, scaling
    logic signed [EW-1:0] pr, pi, pr_r, pi_r, xr, xi, yr, yi;
    logic [DATA_W:0]      nxr, nxi, nyr, nyi;
    logic                 ovf_d;

    always_comb begin
        pr   = EW'(s2_rr) - EW'(s2_ii);
        pi   = EW'(s2_ri) + EW'(s2_ir);
        pr_r = (pr + RND) >>> (TW_W - 2);
        pi_r = (pi + RND) >>> (TW_W - 2);
        xr   = EW'(s2_ar) + pr_r;
        xi   = EW'(s2_ai) + pi_r;
        yr   = EW'(s2_ar) - pr_r;
        yi   = EW'(s2_ai) - pi_r;
        if (SCALE != 0) begin
            xr = (xr + ONE) >>> 1;
            xi = (xi + ONE) >>> 1;
            yr = (yr + ONE) >>> 1;
            yi = (yi + ONE) >>> 1;
        end
        nxr = narrow(xr);
        nxi = narrow(xi);
        nyr = narrow(yr);
        nyi = narrow(yi);
`ifdef BFLY_SAT_EN
        ovf_d = nxr[DATA_W] | nxi[DATA_W] | nyr[DATA_W] | nyi[DATA_W];
`else
        ovf_d = 1'b0;
`endif
    end

`ifndef BFLY_SAT_EN
    // Clip flags have no consumer in the wrapping build.
    logic unused_clip;
    assign unused_clip = nxr[DATA_W] ^ nxi[DATA_W] ^ nyr[DATA_W] ^ nyi[DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
            s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
            s1_wr <= '0; s1_wi <= '0;
            s2_ar <= '0; s2_ai <= '0;
            s2_rr <= '0; s2_ii <= '0; s2_ri <= '0; s2_ir <= '0;
            x_re <= '0;  x_im <= '0;  y_re <= '0;  y_im <= '0;
            ovf  <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en1 && in_valid) begin
                s1_ar <= a_re;
                s1_ai <= a_im;
                s1_br <= b_re;
                s1_bi <= b_im;
                s1_wr <= rom_wr[tw_idx];
                s1_wi <= rom_wi[tw_idx];
            end

            if (en2) v2 <= v1;
            if (en2 && v1) begin
                s2_ar <= s1_ar;
                s2_ai <= s1_ai;
                s2_rr <= PW'(s1_br) * PW'(s1_wr);
                s2_ii <= PW'(s1_bi) * PW'(s1_wi);
                s2_ri <= PW'(s1_br) * PW'(s1_wi);
                s2_ir <= PW'(s1_bi) * PW'(s1_wr);
            end

            if (en3) v3 <= v2;
            if (en3 && v2) begin
                x_re <= nxr[DATA_W-1:0];
                x_im <= nxi[DATA_W-1:0];
                y_re <= nyr[DATA_W-1:0];
                y_im <= nyi[DATA_W-1:0];
                ovf  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Testbench for radix2_bfly_pipe (N=8, DATA_W=8, TW_W=8). A second instance
// with SCALE=1 shares all inputs and runs in lockstep with the main one.
module tb_radix2_bfly_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              in_valid, out_ready;
    logic signed [7:0] a_re, a_im, b_re, b_im;
    logic [1:0]        tw_idx;
    logic              in_ready, out_valid, ovf;
    logic signed [7:0] x_re, x_im, y_re, y_im;
    logic              s_in_ready, s_out_valid, s_ovf;
    logic signed [7:0] s_x_re, s_x_im, s_y_re, s_y_im;

    radix2_bfly_pipe #(.DATA_W(8), .TW_W(8), .N(8), .SCALE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im), .ovf(ovf)
    );

    radix2_bfly_pipe #(.DATA_W(8), .TW_W(8), .N(8), .SCALE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .x_re(s_x_re), .x_im(s_x_im), .y_re(s_y_re), .y_im(s_y_im), .ovf(s_ovf)
    );

    wire [32:0] got   = {ovf, x_re, x_im, y_re, y_im};
    wire [32:0] got_s = {s_ovf, s_x_re, s_x_im, s_y_re, s_y_im};

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    function automatic logic [32:0] pk(input logic o, input int xr, input int xi,
                                       input int yr, input int yi);
        return {o, xr[7:0], xi[7:0], yr[7:0], yi[7:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int ar, input int ai,
                         input int br, input int bi, input int k);
        in_valid = v;
        a_re = ar[7:0];
        a_im = ai[7:0];
        b_re = br[7:0];
        b_im = bi[7:0];
        tw_idx = k[1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1, 5, 5, 5, 5, 0);
        repeat (3) step();
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        n_cmp++;
        if ({out_valid, got} !== 34'd0) begin
            n_bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, got});
        end
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
        step();
    endtask

    // Single vectors with out_ready=1: latency, values, one-cycle out_valid.
    task automatic test_basic();
        int          ar[4] = '{10, 0, 0, 127};
        int          br[4] = '{20, 16, 64, 127};
        int          kk[4] = '{0, 2, 1, 0};
        logic [32:0] ex[4];
        logic [32:0] exs[4];
        int          lat;
        ex[0] = pk(0, 30, 0, -10, 0);
        ex[1] = pk(0, 0, -16, 0, 16);
        ex[2] = pk(0, 45, -45, -45, 45);
`ifdef BFLY_SAT_EN
        ex[3] = pk(1, 127, 0, 0, 0);
`else
        ex[3] = pk(0, -2, 0, 0, 0);
`endif
        exs[0] = pk(0, 15, 0, -5, 0);
        exs[1] = pk(0, 0, -8, 0, 8);
        exs[2] = pk(0, 23, -22, -22, 23);
        exs[3] = pk(0, 127, 0, 0, 0);
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            drive(1, ar[t], 0, br[t], 0, kk[t]);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++; $display("FAIL basic%0d_in_ready got=%b want=1", t, in_ready);
            end
            step();
            drive(0, 0, 0, 0, 0, 0);
            lat = 1;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            n_cmp++;
            if (lat !== 3) begin
                n_bad++; $display("FAIL basic%0d_latency got=%0d want=3", t, lat);
            end
            n_cmp++;
            if (got !== ex[t]) begin
                n_bad++; $display("FAIL basic%0d_value got=%h want=%h", t, got, ex[t]);
            end
            n_cmp++;
            if ({s_out_valid, got_s} !== {1'b1, exs[t]}) begin
                n_bad++; $display("FAIL basic%0d_scaled got=%h want=%h", t,
                                  {s_out_valid, got_s}, {1'b1, exs[t]});
            end
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL basic%0d_one_cycle got=%b want=0", t, out_valid);
            end
        end
    endtask

    // Six vectors streamed; out_ready low in cycles 4..7.
    task automatic test_back_to_back();
        int          ar[6] = '{1, 5, -7, 0, 20, -100};
        int          ai[6] = '{2, 5, 3, 0, -20, 50};
        int          br[6] = '{3, 10, 2, 64, 0, -20};
        int          bi[6] = '{4, 0, -6, 0, 8, -30};
        int          kk[6] = '{0, 2, 0, 3, 2, 0};
        int          sent = 0;
        int          c = 0;
        logic        held = 1'b0;
        logic [32:0] held_v = '0;
        logic        rdy_exp;
        exp_q.delete();
        exp_q.push_back(pk(0, 4, 6, -2, -2));
        exp_q.push_back(pk(0, 5, -5, 5, 15));
        exp_q.push_back(pk(0, -5, -3, -9, 9));
        exp_q.push_back(pk(0, -45, -45, 45, 45));
        exp_q.push_back(pk(0, 28, -20, 12, -20));
        exp_q.push_back(pk(0, -120, 20, -80, 80));
        while (exp_q.size() > 0 && c < 40) begin
            out_ready = !(c >= 4 && c <= 7);
            if (sent < 6) drive(1, ar[sent], ai[sent], br[sent], bi[sent], kk[sent]);
            else          drive(0, 0, 0, 0, 0, 0);
            #1;
            if (c <= 9) begin
                rdy_exp = !(c >= 4 && c <= 7);
                n_cmp++;
                if (in_ready !== rdy_exp) begin
                    n_bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=%b", c, in_ready, rdy_exp);
                end
            end
            if (held) begin
                n_cmp++;
                if ({out_valid, got} !== {1'b1, held_v}) begin
                    n_bad++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c,
                                      {out_valid, got}, {1'b1, held_v});
                end
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (got !== exp_q[0]) begin
                    n_bad++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end else if (out_valid) begin
                held = 1'b1;
                held_v = got;
            end
            if (in_valid && in_ready) sent++;
            step();
            c++;
        end
        n_cmp++;
        if (exp_q.size() !== 0 || sent !== 6) begin
            n_bad++; $display("FAIL b2b_complete left=%0d sent=%0d want 0/6", exp_q.size(), sent);
        end
        drive(0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    // Reset with two vectors in flight: nothing stale ever emerges.
    task automatic test_reset_inflight();
        int seen = 0;
        int lat;
        out_ready = 1'b1;
        drive(1, 11, 11, 11, 11, 0);
        step();
        drive(1, 22, 22, 22, 22, 1);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_flight_in_ready got=%b want=0", in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, got, in_ready} !== {1'b0, 33'd0, 1'b1}) begin
            n_bad++; $display("FAIL rst_flight_state got=%h want=%h",
                              {out_valid, got, in_ready}, {1'b0, 33'd0, 1'b1});
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen++;
            step();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL rst_flight_stale got=%0d want=0", seen);
        end
        drive(1, 3, -4, 5, 6, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL rst_flight_latency got=%0d want=3", lat);
        end
        n_cmp++;
        if (got !== pk(0, 8, 2, -2, -10)) begin
            n_bad++; $display("FAIL rst_flight_value got=%h want=%h", got, pk(0, 8, 2, -2, -10));
        end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
